b03_queue_arbiter: RTL and testbench

- Sequential arbiter that shares one resource among four requesters (REQUEST1..REQUEST4).
- Pending requesters are kept in a 4-entry FIFO queue of 2-bit requester IDs, so grants are issued in arrival order.
- Each grant is held for a fixed number of cycles.
- Sits in the resource-control layer beside the b03 datapath and drives the one-hot GRANT_O lines that select the resource owner.

---
 rtl/b03_queue_arbiter_if.sv | 22 ++
 rtl/b03_queue_arbiter.sv | 176 +++++++++++++++++
 tb/tb_b03_queue_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/b03_queue_arbiter_if.sv
// Request/grant bundle between the four requesters and the b03 queue arbiter.
// The master side drives the requests; the slave (arbiter) side drives grant and status.
interface b03_queue_arbiter_if;
    logic       REQUEST1;
    logic       REQUEST2;
    logic       REQUEST3;
    logic       REQUEST4;
    logic [3:0] GRANT_O;
    logic       BUSY;
    logic [2:0] QUEUE_COUNT;
    logic       QUEUE_ERR;

    modport master (
        output REQUEST1, REQUEST2, REQUEST3, REQUEST4,
        input  GRANT_O, BUSY, QUEUE_COUNT, QUEUE_ERR
    );

    modport slave (
        input  REQUEST1, REQUEST2, REQUEST3, REQUEST4,
        output GRANT_O, BUSY, QUEUE_COUNT, QUEUE_ERR
    );
endinterface

// File: rtl/b03_queue_arbiter.sv
// FIFO-ordered arbiter for four requesters: requests are queued by arrival
// (ID0 > ID3 on a tie) and each grant is held for GRANT_HOLD cycles.
module b03_queue_arbiter #(
    parameter int unsigned GRANT_HOLD = 2,
    parameter int unsigned QDEPTH     = 4
) (
    input  logic                 CLOCK,
    input  logic                 RESET_N,
    b03_queue_arbiter_if.slave   bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam logic [3:0] HOLD_M1  = 4'(GRANT_HOLD - 1);

    function automatic logic [3:0] onehot_id(input logic [1:0] id);
        logic [3:0] oh;
        case (id)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    logic [0:0] state_q, state_d;
    logic [1:0] mem_q [4];
    logic [1:0] mem_d [4];
    logic [1:0] head_q, head_d;
    logic [1:0] tail_q, tail_d;
    logic [2:0] count_q, count_d;
    logic [3:0] fu_q, fu_d;
    logic [3:0] hold_q, hold_d;
    logic [1:0] gid_q, gid_d;
    logic [3:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

    logic [3:0] req_s;
    logic [3:0] elig_s;
    logic       push_s;
    logic       push_ok_s;
    logic       pop_s;
    logic [1:0] push_id_s;

    assign req_s  = {bus.REQUEST4, bus.REQUEST3, bus.REQUEST2, bus.REQUEST1};
    // A requester with a pending entry is masked so it can never be queued twice.
    assign elig_s = req_s & ~fu_q;

    // Fixed-priority pick of the single requester enqueued on this edge.
    always_comb begin
        push_s    = 1'b1;
        push_id_s = 2'd0;
        if (elig_s[0]) begin
            push_id_s = 2'd0;
        end else if (elig_s[1]) begin
            push_id_s = 2'd1;
        end else if (elig_s[2]) begin
            push_id_s = 2'd2;
        end else if (elig_s[3]) begin
            push_id_s = 2'd3;
        end else begin
            push_s    = 1'b0;
        end
    end

    assign push_ok_s = push_s && (count_q != 3'(QDEPTH));

    // Next-state logic for the grant FSM, the queue and the pending flags.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        fu_d    = fu_q;
        hold_d  = hold_q;
        gid_d   = gid_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        err_d   = err_q;
        pop_s   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_d[i] = mem_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (count_q != 3'd0) begin
                    pop_s   = 1'b1;
                    gid_d   = mem_q[head_q];
                    grant_d = onehot_id(mem_q[head_q]);
                    busy_d  = 1'b1;
                    hold_d  = HOLD_M1;
                    head_d  = head_q + 2'd1;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (hold_q != 4'd0) begin
                    hold_d = hold_q - 4'd1;
                end else begin
                    grant_d     = 4'b0000;
                    busy_d      = 1'b0;
                    fu_d[gid_q] = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                grant_d = 4'b0000;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // The granted ID's flag is still set here, so this never collides with the clear above.
        if (push_s) begin
            if (push_ok_s) begin
                mem_d[tail_q]   = push_id_s;
                tail_d          = tail_q + 2'd1;
                fu_d[push_id_s] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            err_d = err_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // State and output registers; reset drops any live grant immediately.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            count_q <= 3'd0;
            fu_q    <= 4'b0000;
            hold_q  <= 4'd0;
            gid_q   <= 2'd0;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 2'd0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fu_q    <= fu_d;
            hold_q  <= hold_d;
            gid_q   <= gid_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.GRANT_O     = grant_q;
    assign bus.BUSY        = busy_q;
    assign bus.QUEUE_COUNT = count_q;
    assign bus.QUEUE_ERR   = err_q;

endmodule

// File: tb/tb_b03_queue_arbiter.sv
// Directed bench for b03_queue_arbiter: a vector table for single-request and
// saturation traffic, plus sequences for ordering, push/pop, reset and GRANT_HOLD=1.
module tb_b03_queue_arbiter;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] grant;
        logic       busy;
        logic [2:0] count;
    } vec_t;

    logic CLOCK;
    logic RESET_N;
    int   n_checks;
    int   n_errors;
    vec_t vecs[$];

    b03_queue_arbiter_if bus2 ();
    b03_queue_arbiter_if bus1 ();

    b03_queue_arbiter #(.GRANT_HOLD(2), .QDEPTH(4)) dut2 (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (bus2.slave)
    );

    b03_queue_arbiter #(.GRANT_HOLD(1), .QDEPTH(4)) dut1 (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (bus1.slave)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic set_req2(input logic [3:0] r);
        {bus2.REQUEST4, bus2.REQUEST3, bus2.REQUEST2, bus2.REQUEST1} = r;
    endtask

    task automatic set_req1(input logic [3:0] r);
        {bus1.REQUEST4, bus1.REQUEST3, bus1.REQUEST2, bus1.REQUEST1} = r;
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic b, input logic [2:0] c);
        vec_t v;
        v.req = r; v.grant = g; v.busy = b; v.count = c;
        vecs.push_back(v);
    endtask

    task automatic chk2(input string nm, input logic [3:0] g, input logic [2:0] c);
        chk({nm, "_grant"}, 8'(bus2.GRANT_O), 8'(g));
        chk({nm, "_count"}, 8'(bus2.QUEUE_COUNT), 8'(c));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RESET_N  = 1'b0;
        set_req2(4'b0000);
        set_req1(4'b0000);

        // Single REQUEST2, then dropped once granted.
        add(4'b0010, 4'b0000, 1'b0, 3'd1);
        add(4'b0010, 4'b0010, 1'b1, 3'd0);
        add(4'b0010, 4'b0010, 1'b1, 3'd0);
        add(4'b0000, 4'b0000, 1'b0, 3'd0);
        add(4'b0000, 4'b0000, 1'b0, 3'd0);
        // All four held: arrival order then round-robin re-enqueue.
        add(4'b1111, 4'b0000, 1'b0, 3'd1);
        add(4'b1111, 4'b0001, 1'b1, 3'd1);
        add(4'b1111, 4'b0001, 1'b1, 3'd2);
        add(4'b1111, 4'b0000, 1'b0, 3'd3);
        add(4'b1111, 4'b0010, 1'b1, 3'd3);
        add(4'b1111, 4'b0010, 1'b1, 3'd3);
        add(4'b1111, 4'b0000, 1'b0, 3'd3);
        add(4'b1111, 4'b0100, 1'b1, 3'd3);
        add(4'b1111, 4'b0100, 1'b1, 3'd3);
        add(4'b1111, 4'b0000, 1'b0, 3'd3);
        add(4'b1111, 4'b1000, 1'b1, 3'd3);
        add(4'b1111, 4'b1000, 1'b1, 3'd3);
        add(4'b1111, 4'b0000, 1'b0, 3'd3);
        add(4'b1111, 4'b0001, 1'b1, 3'd3);
        add(4'b1111, 4'b0001, 1'b1, 3'd3);
        // Requests dropped: queued entries still drain in order.
        add(4'b0000, 4'b0000, 1'b0, 3'd3);
        add(4'b0000, 4'b0010, 1'b1, 3'd2);
        add(4'b0000, 4'b0010, 1'b1, 3'd2);
        add(4'b0000, 4'b0000, 1'b0, 3'd2);
        add(4'b0000, 4'b0100, 1'b1, 3'd1);
        add(4'b0000, 4'b0100, 1'b1, 3'd1);
        add(4'b0000, 4'b0000, 1'b0, 3'd1);
        add(4'b0000, 4'b1000, 1'b1, 3'd0);
        add(4'b0000, 4'b1000, 1'b1, 3'd0);
        add(4'b0000, 4'b0000, 1'b0, 3'd0);
        add(4'b0000, 4'b0000, 1'b0, 3'd0);

        step();
        step();
        chk("rst_grant", 8'(bus2.GRANT_O), 8'h00);
        chk("rst_busy",  8'(bus2.BUSY), 8'h00);
        chk("rst_count", 8'(bus2.QUEUE_COUNT), 8'h00);
        chk("rst_err",   8'(bus2.QUEUE_ERR), 8'h00);
        RESET_N = 1'b1;

        foreach (vecs[i]) begin
            set_req2(vecs[i].req);
            step();
            chk($sformatf("vec%0d_grant", i), 8'(bus2.GRANT_O), 8'(vecs[i].grant));
            chk($sformatf("vec%0d_busy", i),  8'(bus2.BUSY), 8'(vecs[i].busy));
            chk($sformatf("vec%0d_count", i), 8'(bus2.QUEUE_COUNT), 8'(vecs[i].count));
            chk($sformatf("vec%0d_err", i),   8'(bus2.QUEUE_ERR), 8'h00);
        end

        // Arrival order beats priority: ID3 queued before ID0.
        set_req2(4'b1000); step(); chk2("arr1", 4'b0000, 3'd1);
        set_req2(4'b0000); step(); chk2("arr2", 4'b1000, 3'd0);
        set_req2(4'b0001); step(); chk2("arr3", 4'b1000, 3'd1);
        step();                    chk2("arr4", 4'b0000, 3'd1);
        set_req2(4'b0000); step(); chk2("arr5", 4'b0001, 3'd0);
        step(); step();            chk2("arr7", 4'b0000, 3'd0);

        // Push of ID2 on the same edge ID1 is popped.
        set_req2(4'b0010); step(); chk2("pp1", 4'b0000, 3'd1);
        set_req2(4'b0100); step(); chk2("pp2", 4'b0010, 3'd1);
        step();                    chk2("pp3", 4'b0010, 3'd1);
        step();                    chk2("pp4", 4'b0000, 3'd1);
        step();                    chk2("pp5", 4'b0100, 3'd0);

        // Reset mid-grant drops GRANT_O without a clock edge.
        #2 RESET_N = 1'b0;
        #1;
        chk2("rmg", 4'b0000, 3'd0);
        chk("rmg_busy", 8'(bus2.BUSY), 8'h00);
        #2 RESET_N = 1'b1;
        step();                    chk2("rmg_re1", 4'b0000, 3'd1);
        step();                    chk2("rmg_re2", 4'b0100, 3'd0);
        set_req2(4'b0000);

        // GRANT_HOLD=1: one-cycle grant, idle gap, then re-grant of the held request.
        set_req1(4'b0001);
        step(); chk("h1_e1", 8'(bus1.GRANT_O), 8'h00);
        chk("h1_e1_count", 8'(bus1.QUEUE_COUNT), 8'h01);
        step(); chk("h1_e2", 8'(bus1.GRANT_O), 8'h01);
        chk("h1_e2_busy", 8'(bus1.BUSY), 8'h01);
        step(); chk("h1_e3", 8'(bus1.GRANT_O), 8'h00);
        step(); chk("h1_e4", 8'(bus1.GRANT_O), 8'h00);
        chk("h1_e4_count", 8'(bus1.QUEUE_COUNT), 8'h01);
        step(); chk("h1_e5", 8'(bus1.GRANT_O), 8'h01);
        set_req1(4'b0000);
        step(); chk("h1_e6", 8'(bus1.GRANT_O), 8'h00);
        chk("h1_err", 8'(bus1.QUEUE_ERR), 8'h00);
        chk("end_err", 8'(bus2.QUEUE_ERR), 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
